// File: rtl/expr_tokenizer.sv
// ASCII character stream to number/operator token stream for the expression parser.
// Optional sticky error flag (illegal char, accumulation overflow): define EXPR_TOKENIZER_ERR_EN.
module expr_tokenizer #(
   parameter int DATA_W = 32,
   parameter int CHAR_W = 8
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              char_stb,
   input  logic [CHAR_W-1:0] char_data,
   output logic              char_ack,
   output logic              tok_stb,
   output logic [DATA_W-1:0] tok_data,
   output logic              tok_is_operator,
   input  logic              tok_ack,
   output logic              expr_done,
   output logic              err
);

   typedef enum logic [2:0] {S_IDLE, S_NUM, S_EMIT_NUM, S_EMIT_OP, S_DONE} state_t;

`ifdef EXPR_TOKENIZER_ERR_EN
   localparam int XW = DATA_W + 4;  // headroom to see the carry out of acc*10+digit
`else
   localparam int XW = DATA_W;
`endif

   state_t            state, state_nxt;
   logic [DATA_W-1:0] acc, acc_nxt;
   logic [DATA_W-1:0] tok_q, tok_nxt;
   logic              tok_op_q, tok_op_nxt;
   logic [CHAR_W-1:0] pend_op, pend_op_nxt;
   logic              pend_op_vld, pend_op_vld_nxt;
   logic              pend_term, pend_term_nxt;
   logic              take;
   logic              is_digit, is_op, is_ws, is_term;
   logic [3:0]        digit;
   logic [XW-1:0]     acc_ext, acc_step;

   assign digit    = char_data[3:0];
   assign acc_ext  = XW'(acc);
   assign acc_step = (acc_ext << 3) + (acc_ext << 1) + XW'(digit);

   always_comb begin
      is_digit = 1'b0;
      is_op    = 1'b0;
      is_ws    = 1'b0;
      is_term  = 1'b0;
      case (char_data)
         CHAR_W'(8'h30), CHAR_W'(8'h31), CHAR_W'(8'h32), CHAR_W'(8'h33), CHAR_W'(8'h34),
         CHAR_W'(8'h35), CHAR_W'(8'h36), CHAR_W'(8'h37), CHAR_W'(8'h38), CHAR_W'(8'h39):
            is_digit = 1'b1;
         CHAR_W'(8'h2B), CHAR_W'(8'h2D), CHAR_W'(8'h2A), CHAR_W'(8'h2F),
         CHAR_W'(8'h28), CHAR_W'(8'h29):
            is_op = 1'b1;
         CHAR_W'(8'h20), CHAR_W'(8'h09), CHAR_W'(8'h0A), CHAR_W'(8'h0D):
            is_ws = 1'b1;
         CHAR_W'(8'h3D):
            is_term = 1'b1;
         default: ;
      endcase
   end

   // Reset gates char_ack so nothing is handshaken while RST is held low.
   assign char_ack        = RST && (state == S_IDLE || state == S_NUM);
   assign take            = char_stb && char_ack;
   assign tok_stb         = (state == S_EMIT_NUM) || (state == S_EMIT_OP);
   assign tok_data        = tok_q;
   assign tok_is_operator = tok_op_q;
   assign expr_done       = (state == S_DONE);

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) state <= S_IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt       = state;
      acc_nxt         = acc;
      tok_nxt         = tok_q;
      tok_op_nxt      = tok_op_q;
      pend_op_nxt     = pend_op;
      pend_op_vld_nxt = pend_op_vld;
      pend_term_nxt   = pend_term;
      case (state)
         S_IDLE: begin
            if (take) begin
               if (is_digit) begin
                  acc_nxt   = DATA_W'(digit);
                  state_nxt = S_NUM;
               end else if (is_op) begin
                  tok_nxt    = DATA_W'(char_data);
                  tok_op_nxt = 1'b1;
                  state_nxt  = S_EMIT_OP;
               end else if (is_term) begin
                  state_nxt = S_DONE;
               end
            end
         end
         S_NUM: begin
            if (take) begin
               if (is_digit) begin
                  acc_nxt = acc_step[DATA_W-1:0];
               end else begin
                  // Any non-digit closes the number; remember what closed it.
                  tok_nxt         = acc;
                  tok_op_nxt      = 1'b0;
                  pend_op_nxt     = char_data;
                  pend_op_vld_nxt = is_op;
                  pend_term_nxt   = is_term;
                  state_nxt       = S_EMIT_NUM;
               end
            end
         end
         S_EMIT_NUM: begin
            if (tok_ack) begin
               if (pend_op_vld) begin
                  tok_nxt         = DATA_W'(pend_op);
                  tok_op_nxt      = 1'b1;
                  pend_op_vld_nxt = 1'b0;
                  state_nxt       = S_EMIT_OP;
               end else if (pend_term) begin
                  pend_term_nxt = 1'b0;
                  state_nxt     = S_DONE;
               end else begin
                  state_nxt = S_IDLE;
               end
            end
         end
         S_EMIT_OP: if (tok_ack) state_nxt = S_IDLE;
         S_DONE:    state_nxt = S_IDLE;
         default:   state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         acc         <= '0;
         tok_q       <= '0;
         tok_op_q    <= 1'b0;
         pend_op     <= '0;
         pend_op_vld <= 1'b0;
         pend_term   <= 1'b0;
      end else begin
         acc         <= acc_nxt;
         tok_q       <= tok_nxt;
         tok_op_q    <= tok_op_nxt;
         pend_op     <= pend_op_nxt;
         pend_op_vld <= pend_op_vld_nxt;
         pend_term   <= pend_term_nxt;
      end
   end

`ifdef EXPR_TOKENIZER_ERR_EN
   logic err_q, err_set, ovf;

   assign ovf     = |acc_step[XW-1:DATA_W];
   assign err_set = take && ((!is_digit && !is_op && !is_ws && !is_term) ||
                             (state == S_NUM && is_digit && ovf));

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST)        err_q <= 1'b0;
      else if (err_set) err_q <= 1'b1;
   end
   assign err = err_q;
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_expr_tokenizer.sv
// Directed bench for expr_tokenizer: expected tokens queued as characters are sent,
// popped and compared as tokens / expr_done pulses appear.
module tb_expr_tokenizer;
   localparam int DATA_W = 32;
   localparam int CHAR_W = 8;
`ifdef EXPR_TOKENIZER_ERR_EN
   localparam logic ERR_EN = 1'b1;
`else
   localparam logic ERR_EN = 1'b0;
`endif

   logic              CLK = 1'b0;
   logic              RST;
   logic              char_stb;
   logic [CHAR_W-1:0] char_data;
   logic              char_ack;
   logic              tok_stb;
   logic [DATA_W-1:0] tok_data;
   logic              tok_is_operator;
   logic              tok_ack;
   logic              expr_done;
   logic              err;

   expr_tokenizer #(.DATA_W(DATA_W), .CHAR_W(CHAR_W)) dut (
      .CLK(CLK), .RST(RST),
      .char_stb(char_stb), .char_data(char_data), .char_ack(char_ack),
      .tok_stb(tok_stb), .tok_data(tok_data), .tok_is_operator(tok_is_operator),
      .tok_ack(tok_ack), .expr_done(expr_done), .err(err)
   );

   always #5 CLK = ~CLK;

   // kind: 0 number, 1 operator, 2 expr_done pulse
   typedef struct packed {
      logic [1:0]        kind;
      logic [DATA_W-1:0] data;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic exp_num(input logic [DATA_W-1:0] v);
      sb.push_back('{kind: 2'd0, data: v});
   endtask
   task automatic exp_op(input logic [7:0] c);
      sb.push_back('{kind: 2'd1, data: DATA_W'(c)});
   endtask
   task automatic exp_done();
      sb.push_back('{kind: 2'd2, data: '0});
   endtask

   // Called mid-cycle: a token handshake or done pulse seen here is popped from the scoreboard.
   task automatic observe();
      exp_t e;
      logic [1:0] k;
      if ((tok_stb && tok_ack) || expr_done) begin
         k = expr_done ? 2'd2 : (tok_is_operator ? 2'd1 : 2'd0);
         if (sb.size() == 0) begin
            chk("extra_output", 64'(sb.size()), 64'd1);
         end else begin
            e = sb.pop_front();
            chk("out_kind", 64'(k), 64'(e.kind));
            if (e.kind != 2'd2) chk("tok_data", 64'(tok_data), 64'(e.data));
         end
      end
   endtask

   task automatic cycle();
      @(negedge CLK);
      observe();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic send_char(input logic [7:0] c);
      logic accepted;
      accepted  = 1'b0;
      char_stb  = 1'b1;
      char_data = c;
      for (int n = 0; n < 50 && !accepted; n++) begin
         @(negedge CLK);
         observe();
         accepted = char_ack;
         @(posedge CLK);
         #1;
      end
      chk("char_accept", 64'(accepted), 64'd1);
      char_stb = 1'b0;
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send_char(s[i]);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_tok_stb"},   64'(tok_stb), 64'd0);
      chk({tag, "_tok_data"},  64'(tok_data), 64'd0);
      chk({tag, "_tok_is_op"}, 64'(tok_is_operator), 64'd0);
      chk({tag, "_expr_done"}, 64'(expr_done), 64'd0);
      chk({tag, "_err"},       64'(err), 64'd0);
      chk({tag, "_char_ack"},  64'(char_ack), 64'd0);
   endtask

   initial begin
      RST       = 1'b0;
      char_stb  = 1'b0;
      char_data = '0;
      tok_ack   = 1'b1;

      @(negedge CLK);
      chk_reset_outputs("rst");
      @(posedge CLK);
      #1;
      RST = 1'b1;
      idle(2);

      // "12+3*4="
      exp_num(12); exp_op(8'h2B); exp_num(3); exp_op(8'h2A); exp_num(4); exp_done();
      send_str("12+3*4=");
      idle(6);
      chk("t1_drained", 64'(sb.size()), 64'd0);

      // "(7 )="
      exp_op(8'h28); exp_num(7); exp_op(8'h29); exp_done();
      send_str("(7 )=");
      idle(6);
      chk("t2_drained", 64'(sb.size()), 64'd0);

      // "45+" under backpressure, '=' offered throughout the stall
      tok_ack = 1'b0;
      exp_num(45); exp_op(8'h2B); exp_done();
      send_str("45+");
      char_stb  = 1'b1;
      char_data = 8'h3D;
      for (int i = 0; i < 6; i++) begin
         @(negedge CLK);
         chk("bp_tok_stb",   64'(tok_stb), 64'd1);
         chk("bp_tok_data",  64'(tok_data), 64'd45);
         chk("bp_tok_is_op", 64'(tok_is_operator), 64'd0);
         chk("bp_char_ack",  64'(char_ack), 64'd0);
         observe();
         @(posedge CLK);
         #1;
      end
      tok_ack = 1'b1;
      send_char(8'h3D);
      idle(6);
      chk("t3_drained", 64'(sb.size()), 64'd0);
      chk("t3_err", 64'(err), 64'd0);

      // 2^32 wraps to 0
      exp_num(0); exp_done();
      send_str("4294967296=");
      idle(6);
      chk("wrap_drained", 64'(sb.size()), 64'd0);
      chk("wrap_err", 64'(err), 64'(ERR_EN));

      // reset in the middle of a number
      send_str("56");
      RST = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge CLK);
         chk_reset_outputs("midrst");
         @(posedge CLK);
         #1;
      end
      RST = 1'b1;
      exp_num(9); exp_done();
      send_str("9=");
      idle(6);
      chk("midrst_drained", 64'(sb.size()), 64'd0);
      chk("midrst_err", 64'(err), 64'd0);

      // illegal character terminates the number
      exp_num(5); exp_num(6); exp_done();
      send_str("5a6=");
      idle(6);
      chk("illegal_drained", 64'(sb.size()), 64'd0);
      chk("illegal_err", 64'(err), 64'(ERR_EN));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
